// File: rtl/dm_rmw_ctrl.sv
// rtl/dm_rmw_ctrl.sv - MEM-stage sequencer for a word-wide RAM with read-modify-write sub-word stores
module dm_rmw_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic [1:0]        rd_byte,
    output logic              err_misalign,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        RMW_RD  = 2'd2,
        RMW_WR  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            state;
    logic [ADDR_W-1:0] lat_addr;
    logic [1:0]        lat_off;
    logic [1:0]        lat_size;
    logic [31:0]       lat_wdata;
    logic [31:0]       merged;
    logic [31:0]       merge_word;
    logic              accept;
    logic              misalign;
    logic              unused_addr_hi;

    // Address bits above the RAM range wrap silently.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign misalign  = (req_size == 2'b11)
                     || ((req_size == SZ_HALF) && req_addr[0])
                     || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    always_comb begin
        merge_word = ram_rdata;
        if (lat_size == SZ_BYTE) begin
            case (lat_off)
                2'd0:    merge_word[7:0]   = lat_wdata[7:0];
                2'd1:    merge_word[15:8]  = lat_wdata[7:0];
                2'd2:    merge_word[23:16] = lat_wdata[7:0];
                default: merge_word[31:24] = lat_wdata[7:0];
            endcase
        end else if (lat_off[1]) begin
            merge_word[31:16] = lat_wdata[15:0];
        end else begin
            merge_word[15:0] = lat_wdata[15:0];
        end
    end

    // RAM strobes accompany the accepting cycle, so they cannot be registered.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = lat_addr;
        ram_wdata = merged;
        if (state == IDLE) begin
            ram_addr  = req_addr[ADDR_W+1:2];
            ram_wdata = req_wdata;
            if (accept && !misalign) begin
                if (req_we && (req_size == SZ_WORD)) ram_we = 1'b1;
                else                                 ram_en = 1'b1;
            end
        end else if (state == RMW_WR) begin
            ram_we = !reset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            rd_byte      <= '0;
            err_misalign <= 1'b0;
            lat_addr     <= '0;
            lat_off      <= '0;
            lat_size     <= '0;
            lat_wdata    <= '0;
            merged       <= '0;
        end else begin
            rd_valid     <= 1'b0;
            err_misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (misalign) begin
                            err_misalign <= 1'b1;
                        end else if (!(req_we && (req_size == SZ_WORD))) begin
                            lat_addr  <= req_addr[ADDR_W+1:2];
                            lat_off   <= req_addr[1:0];
                            lat_size  <= req_size;
                            lat_wdata <= req_wdata;
                            state     <= req_we ? RMW_RD : LD_WAIT;
                        end
                    end
                end
                LD_WAIT: begin
                    rd_data  <= ram_rdata;
                    rd_byte  <= lat_off;
                    rd_valid <= 1'b1;
                    state    <= IDLE;
                end
                RMW_RD: begin
                    merged <= merge_word;
                    state  <= RMW_WR;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_rmw_ctrl.sv
// tb/tb_dm_rmw_ctrl.sv - scoreboard bench for dm_rmw_ctrl with a synchronous-read RAM model
module tb_dm_rmw_ctrl;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rd_valid;
    logic [31:0]       rd_data;
    logic [1:0]        rd_byte;
    logic              err_misalign;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    dm_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_byte(rd_byte),
        .err_misalign(err_misalign),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_en) ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        logic [1:0]  off;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   en_cnt = 0;
    int   we_cnt = 0;
    int   low_cnt = 0;
    int   err_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pops on each response pulse.
    always @(negedge clk) begin
        exp_t e;
        if (ram_en) en_cnt++;
        if (ram_we) we_cnt++;
        if (!req_ready && !reset) low_cnt++;
        if (err_misalign) err_cnt++;
        check("en_we_exclusive", {31'b0, ram_en & ram_we}, 32'd0);
        check("valid_err_exclusive", {31'b0, rd_valid & err_misalign}, 32'd0);
        if (rd_valid || err_misalign) begin
            if (q.size() == 0) begin
                check("unexpected_response", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("resp_kind", {31'b0, err_misalign}, {31'b0, e.is_err});
                check("resp_latency", cyc - e.acc, e.is_err ? 32'd1 : 32'd2);
                if (!e.is_err) begin
                    check("rd_data", rd_data, e.data);
                    check("rd_byte", {30'b0, rd_byte}, {30'b0, e.off});
                end
            end
        end
    end

    task automatic send(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic is_err, input logic [31:0] exp_data,
                        output int acc);
        exp_t e;
        bit   ok = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 32'd1, 32'd0);
        end else begin
            acc = cyc;
            if (is_err || !we) begin
                e.is_err = is_err;
                e.data   = exp_data;
                e.off    = addr[1:0];
                e.acc    = acc;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int a0, a1, a2, en0, we0, low0, err0;

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'b10;
        req_addr = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_req_ready", {31'b0, req_ready}, 32'd0);
        check("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("reset_ram_strobes", {30'b0, ram_en, ram_we}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("ready_after_reset", {31'b0, req_ready}, 32'd1);

        // 1: word store then load
        we0 = we_cnt;
        send(1, 2'b10, 32'h10, 32'h12345678, 0, 0, a0);
        idle(1);
        check("sw_one_write", we_cnt - we0, 32'd1);
        check("sw_mem_word4", mem[4], 32'h12345678);
        send(0, 2'b10, 32'h10, 0, 0, 32'h12345678, a0);
        idle(3);

        // 2: byte store RMW
        send(1, 2'b10, 32'h10, 32'h11223344, 0, 0, a0);
        low0 = low_cnt;
        send(1, 2'b00, 32'h12, 32'h000000AB, 0, 0, a0);
        idle(3);
        check("sb_ready_low_cycles", low_cnt - low0, 32'd2);
        check("sb_mem_word4", mem[4], 32'h11AB3344);
        send(0, 2'b00, 32'h12, 0, 0, 32'h11AB3344, a0);
        idle(3);

        // 3: halfword store upper then lower lane
        send(1, 2'b10, 32'h20, 32'h0, 0, 0, a0);
        send(1, 2'b01, 32'h22, 32'h0000BEEF, 0, 0, a0);
        idle(3);
        check("sh_upper_mem", mem[8], 32'hBEEF0000);
        send(1, 2'b01, 32'h20, 32'h0000CAFE, 0, 0, a0);
        idle(3);
        check("sh_lower_mem", mem[8], 32'hBEEFCAFE);

        // 4: misaligned requests, back to back
        en0 = en_cnt; we0 = we_cnt; low0 = low_cnt; err0 = err_cnt;
        send(1, 2'b01, 32'h21, 32'h0000DEAD, 1, 0, a0);
        send(0, 2'b10, 32'h13, 0, 1, 0, a0);
        send(1, 2'b11, 32'h00, 32'hFFFFFFFF, 1, 0, a0);
        idle(3);
        check("mis_err_pulses", err_cnt - err0, 32'd3);
        check("mis_no_ram_en", en_cnt - en0, 32'd0);
        check("mis_no_ram_we", we_cnt - we0, 32'd0);
        check("mis_ready_stays", low_cnt - low0, 32'd0);
        check("mis_mem_word8", mem[8], 32'hBEEFCAFE);
        check("mis_mem_word0", mem[0], 32'hxxxxxxxx);

        // 5: back-to-back with valid held high
        send(1, 2'b10, 32'h30, 32'hFFFFFFFF, 0, 0, a0);
        send(1, 2'b00, 32'h31, 32'h00000000, 0, 0, a1);
        send(0, 2'b10, 32'h30, 0, 0, 32'hFFFF00FF, a2);
        idle(3);
        check("b2b_sb_accept", a1 - a0, 32'd1);
        check("b2b_lw_accept", a2 - a0, 32'd4);

        // 6: reset during RMW_WR
        send(1, 2'b10, 32'h40, 32'h55667788, 0, 0, a0);
        we0 = we_cnt;
        send(1, 2'b00, 32'h40, 32'h00000099, 0, 0, a0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_rmw_no_we", {31'b0, ram_we}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_outputs", {rd_valid, err_misalign, ram_en, ram_we, req_ready, rd_byte}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready_after", {31'b0, req_ready}, 32'd1);
        check("rst_no_write", we_cnt - we0, 32'd0);
        check("rst_mem_word16", mem[16], 32'h55667788);
        @(posedge clk);
        #1;
        send(0, 2'b10, 32'h40, 0, 0, 32'h55667788, a0);
        idle(4);

        check("scoreboard_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_rmw_ctrl.md
Name: dm_rmw_ctrl

Overview:
Sequencer between the pipeline's MEM-stage data port and a word-wide, synchronous-read data RAM with no byte enables.
- Word stores write directly in one cycle.
- Byte and halfword stores go through a read-modify-write sequence.
- Loads return the full 32-bit word plus the byte offset, and the downstream load-extension stage selects and extends the lane.
- While a multi-cycle sequence runs, the block back-pressures the pipeline through req_ready.

Parameters:
ADDR_W, 12, word-address width of the RAM (RAM depth = 2^ADDR_W words)

Ports:
clk  in  1  system clock, all state updates on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  MEM-stage access request
req_ready  out  1  request accepted this cycle (1 only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rd_valid  out  1  one-cycle pulse, load data available
rd_data  out  32  raw RAM word for the load
rd_byte  out  2  req_addr[1:0] of that load
err_misalign  out  1  one-cycle pulse, request rejected
ram_en  out  1  RAM read enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid the cycle after ram_en

Behaviour:
- States: IDLE, LD_WAIT, RMW_RD, RMW_WR.
- Reset:
  - state=IDLE; rd_valid=0, rd_data=0, rd_byte=0, err_misalign=0; latched addr/data/size=0.
  - ram_we and ram_en are forced 0 in any cycle where reset=1, including mid-sequence. An interrupted RMW performs no write.
- req_ready = (state==IDLE) & !reset. A request is accepted only when req_valid & req_ready.
- Address mapping: ram_addr = req_addr[ADDR_W+1:2] in IDLE, the latched word address otherwise. Upper bits are ignored and wrap silently.
- Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - The request is consumed in one cycle with no RAM access.
  - err_misalign=1 on the next cycle; rd_valid stays 0; state stays IDLE.
- Word store accepted: ram_we=1 and ram_wdata=req_wdata in the same cycle; state stays IDLE. Throughput is 1 per cycle.
- Load accepted (cycle T):
  - ram_en=1; addr[1:0] latched; state goes to LD_WAIT.
  - In LD_WAIT (T+1): rd_data<=ram_rdata, rd_byte<=latched offset, rd_valid<=1, state goes to IDLE.
  - rd_valid is high in T+2 only. rd_data/rd_byte hold until the next load completes.
- Sub-word store accepted (cycle T):
  - ram_en=1; word address, offset, size and wdata latched; state goes to RMW_RD.
  - RMW_RD (T+1): merged<=ram_rdata with the target lane replaced.
    - byte: lane offset*8 gets wdata[7:0].
    - half: offset[1]=0 puts wdata[15:0] in [15:0]; offset[1]=1 puts it in [31:16].
  - RMW_WR (T+2): ram_we=1, ram_wdata=merged, latched address; state goes to IDLE.
  - req_ready is low in T+1 and T+2.
- ram_en=0 and ram_we=0 in every cycle not listed above. ram_en and ram_we are never both 1 in the same cycle.
- Ordering: accesses complete strictly in acceptance order. A load accepted right after RMW_WR reads the merged word, because the RAM write lands before the next read.
- rd_valid and err_misalign are never both 1 in the same cycle.

Test Plan:
1. Word store then load:
   - SW 0x12345678 to 0x10, then LW 0x10.
   - Required: ram_we one cycle at addr 4; rd_valid 2 cycles after load accept; rd_data=0x12345678, rd_byte=0.
2. Byte store RMW:
   - Word 0x10 holds 0x11223344; SB wdata=0xAB to 0x12.
   - Required: req_ready low 2 cycles; RAM word becomes 0x11AB3344.
   - A following LB at 0x12 returns rd_data=0x11AB3344, rd_byte=2.
3. Halfword store upper lane:
   - Word 0x20 holds 0x00000000; SH wdata=0xBEEF to 0x22.
   - Required: RAM word becomes 0xBEEF0000.
   - Then SH 0xCAFE to 0x20 gives 0xBEEFCAFE.
4. Misaligned requests:
   - Each of SH to 0x21, LW to 0x13, size=11 to 0x00.
   - Required: err_misalign pulses once per request; no ram_en or ram_we; memory unchanged; req_ready stays 1.
5. Back-to-back traffic:
   - req_valid held high with SW, SB, LW to the same word 0x30.
   - Required: SW 0xFFFFFFFF, then SB 0x00 at 0x31, then LW returns 0xFFFF00FF.
   - Required: accept cycles are T, T+1, T+4.
6. Reset mid-RMW:
   - Assert reset in the RMW_WR cycle of an SB.
   - Required: no write (memory unchanged); all outputs at reset values next cycle; req_ready=1 once reset drops.
